// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage and the
// IF/ID register that consumes its output.
package if_fetch_unit_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      VALID,
      DRAIN
   } fetch_state_t;

   // addi x0,x0,0: bubble used by fetch flushes and by the IF/ID reset value
   localparam word_t NOP_INSTR_C = 32'h0000_0013;
   localparam word_t RESET_PC_C  = 32'h0000_0000;
   localparam word_t ALIGN_MASK  = 32'hFFFF_FFFC;

   // Instructions are word aligned; the two low address bits are forced to zero.
   function automatic word_t word_align(input word_t a);
      return a & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface if_fetch_unit_if;
   import if_fetch_unit_pkg::*;

   logic  req;
   word_t addr;
   logic  rvalid;
   word_t rdata;

   modport master (output req, output addr, input rvalid, input rdata);
   modport slave  (input req, input addr, output rvalid, output rdata);

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time
// and presents {pc_IF, instr_IF} to the IF/ID register, with NOP bubbles
// whenever no fetched instruction is available.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter word_t RESET_PC  = RESET_PC_C,
   parameter word_t NOP_INSTR = NOP_INSTR_C
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            stall,
   input  logic            redirect_valid,
   input  word_t           redirect_pc,
   if_fetch_unit_if.master imem,
   output word_t           pc_IF,
   output word_t           instr_IF,
   output logic            if_valid
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        pc_if_q, pc_if_d;
   word_t        instr_q, instr_d;
   logic         vld_q, vld_d;

   // Next-state and next-output logic; a redirect overrides stall and every state transition.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pc_if_d = pc_if_q;
      instr_d = instr_q;
      vld_d   = vld_q;

      if (redirect_valid) begin
         pc_d    = word_align(redirect_pc);
         vld_d   = 1'b0;
         instr_d = NOP_INSTR;
         unique case (state_q)
            // A request is still in flight unless its response lands this very cycle.
            WAIT, DRAIN: state_d = imem.rvalid ? REQ : DRAIN;
            // REQ is gated off by the redirect, so nothing was sent that needs draining.
            default:     state_d = REQ;
         endcase
      end else begin
         unique case (state_q)
            REQ: state_d = WAIT;
            WAIT: begin
               if (imem.rvalid) begin
                  pc_if_d = pc_q;
                  instr_d = imem.rdata;
                  vld_d   = 1'b1;
                  state_d = VALID;
               end
            end
            VALID: begin
               // IF/ID captures the instruction on any non-stalled cycle.
               if (!stall) begin
                  pc_d    = pc_q + 32'd4;
                  vld_d   = 1'b0;
                  instr_d = NOP_INSTR;
                  state_d = REQ;
               end
            end
            DRAIN: begin
               if (imem.rvalid) state_d = REQ;
            end
            default: state_d = REQ;
         endcase
      end
   end

   // State, PC and presented-instruction registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= REQ;
         pc_q    <= RESET_PC;
         pc_if_q <= RESET_PC;
         instr_q <= NOP_INSTR;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pc_if_q <= pc_if_d;
         instr_q <= instr_d;
         vld_q   <= vld_d;
      end
   end

   assign imem.req  = (state_q == REQ) && !redirect_valid && i_rst_n;
   assign imem.addr = word_align(pc_q);

   assign pc_IF    = pc_if_q;
   assign instr_IF = instr_q;
   assign if_valid = vld_q;

   // A response is only legal while a request is outstanding (WAIT or DRAIN).
   rvalid_only_when_outstanding: assert property (
      @(posedge i_clk) disable iff (!i_rst_n)
      imem.rvalid |-> (state_q == WAIT || state_q == DRAIN));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small latency-programmable imem model.
module tb_if_fetch_unit;
   import if_fetch_unit_pkg::*;

   logic  clk;
   logic  rst_n;
   logic  stall;
   logic  redir;
   word_t rpc;
   word_t pc_IF;
   word_t instr_IF;
   logic  if_valid;

   int    total = 0;
   int    bad   = 0;
   int    lat   = 1;
   int    mem_cnt = 0;
   int    req_cnt = 0;
   int    base;
   word_t mem_addr = '0;

   if_fetch_unit_if imem_bus();

   if_fetch_unit dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .stall          (stall),
      .redirect_valid (redir),
      .redirect_pc    (rpc),
      .imem           (imem_bus),
      .pc_IF          (pc_IF),
      .instr_IF       (instr_IF),
      .if_valid       (if_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic word_t mem_word(input word_t a);
      return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A00_0000);
   endfunction

   // Memory model: response arrives lat cycles after the request edge.
   always @(posedge clk) begin
      if (!rst_n) begin
         mem_cnt <= 0;
      end else if (imem_bus.req) begin
         mem_cnt  <= lat;
         mem_addr <= imem_bus.addr;
         req_cnt  <= req_cnt + 1;
      end else if (mem_cnt > 0) begin
         mem_cnt <= mem_cnt - 1;
      end
   end

   assign imem_bus.rvalid = (mem_cnt == 1);
   assign imem_bus.rdata  = mem_word(mem_addr);

   task automatic chk(input string tag, input word_t obs, input word_t exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      redir = 1'b0;
      rpc   = '0;
      repeat (2) @(posedge clk);
      step(); #1;
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_pc", pc_IF, 32'h0);
      chk("rst_instr", instr_IF, NOP_INSTR_C);
      chk("rst_req", 32'(imem_bus.req), 32'd0);

      // First fetch from address 0 with 1-cycle memory
      rst_n = 1'b1; #1;
      chk("c1_req", 32'(imem_bus.req), 32'd1);
      chk("c1_addr", imem_bus.addr, 32'h0);
      step(); #1;
      chk("c2_req", 32'(imem_bus.req), 32'd0);
      chk("c2_valid", 32'(if_valid), 32'd0);
      chk("c2_instr", instr_IF, NOP_INSTR_C);
      step(); #1;
      chk("c3_valid", 32'(if_valid), 32'd1);
      chk("c3_pc", pc_IF, 32'h0);
      chk("c3_instr", instr_IF, 32'h0050_0093);
      step(); #1;
      chk("c4_req", 32'(imem_bus.req), 32'd1);
      chk("c4_addr", imem_bus.addr, 32'h4);
      chk("c4_valid", 32'(if_valid), 32'd0);
      chk("c4_instr", instr_IF, NOP_INSTR_C);
      step();
      step(); #1;
      chk("pc4_pc", pc_IF, 32'h4);

      // Redirect in VALID to reach pc 0x10
      redir = 1'b1; rpc = 32'h10; #1;
      chk("rv_req", 32'(imem_bus.req), 32'd0);
      step(); redir = 1'b0; #1;
      chk("r10_req", 32'(imem_bus.req), 32'd1);
      chk("r10_addr", imem_bus.addr, 32'h10);
      step();
      step(); #1;
      chk("v10_valid", 32'(if_valid), 32'd1);
      chk("v10_pc", pc_IF, 32'h10);
      chk("v10_instr", instr_IF, 32'h5A00_0010);

      // Stall for 4 cycles while VALID
      stall = 1'b1;
      base  = req_cnt;
      for (int i = 0; i < 4; i++) begin
         step(); #1;
         chk("stl_valid", 32'(if_valid), 32'd1);
         chk("stl_pc", pc_IF, 32'h10);
         chk("stl_instr", instr_IF, 32'h5A00_0010);
         chk("stl_req", 32'(imem_bus.req), 32'd0);
      end
      stall = 1'b0;
      chk("stl_nreq", 32'(req_cnt), 32'(base));

      // 3-cycle memory latency
      step(); lat = 3; #1;
      chk("l3_req", 32'(imem_bus.req), 32'd1);
      chk("l3_addr", imem_bus.addr, 32'h14);
      base = req_cnt;
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         chk("l3w_valid", 32'(if_valid), 32'd0);
         chk("l3w_instr", instr_IF, NOP_INSTR_C);
         chk("l3w_req", 32'(imem_bus.req), 32'd0);
      end
      step(); #1;
      chk("l3_valid", 32'(if_valid), 32'd1);
      chk("l3_pc", pc_IF, 32'h14);
      chk("l3_instr", instr_IF, 32'h5A00_0014);
      chk("l3_nreq", 32'(req_cnt), 32'(base + 1));

      // Redirect in WAIT two cycles before the response -> DRAIN
      step(); #1;
      chk("r18_addr", imem_bus.addr, 32'h18);
      step(); redir = 1'b1; rpc = 32'h0000_0103; #1;
      chk("dw_req", 32'(imem_bus.req), 32'd0);
      step(); redir = 1'b0; #1;
      chk("dr1_valid", 32'(if_valid), 32'd0);
      chk("dr1_instr", instr_IF, NOP_INSTR_C);
      chk("dr1_req", 32'(imem_bus.req), 32'd0);
      step(); #1;
      chk("dr2_valid", 32'(if_valid), 32'd0);
      chk("dr2_instr", instr_IF, NOP_INSTR_C);
      chk("dr2_req", 32'(imem_bus.req), 32'd0);
      step(); lat = 1; #1;
      chk("d100_req", 32'(imem_bus.req), 32'd1);
      chk("d100_addr", imem_bus.addr, 32'h100);
      chk("d100_instr", instr_IF, NOP_INSTR_C);

      // Redirect in the same cycle as rvalid
      step(); redir = 1'b1; rpc = 32'h200; #1;
      chk("rs_req", 32'(imem_bus.req), 32'd0);
      step(); redir = 1'b0; #1;
      chk("rs_valid", 32'(if_valid), 32'd0);
      chk("rs_instr", instr_IF, NOP_INSTR_C);
      chk("rs_req2", 32'(imem_bus.req), 32'd1);
      chk("rs_addr", imem_bus.addr, 32'h200);
      step();
      step(); #1;
      chk("v200_valid", 32'(if_valid), 32'd1);
      chk("v200_pc", pc_IF, 32'h200);
      chk("v200_instr", instr_IF, 32'h5A00_0200);

      // Redirect while stalled in VALID
      stall = 1'b1; redir = 1'b1; rpc = 32'h300; #1;
      chk("rst_stl_req", 32'(imem_bus.req), 32'd0);
      step(); stall = 1'b0; redir = 1'b0; #1;
      chk("r300_valid", 32'(if_valid), 32'd0);
      chk("r300_instr", instr_IF, NOP_INSTR_C);
      chk("r300_req", 32'(imem_bus.req), 32'd1);
      chk("r300_addr", imem_bus.addr, 32'h300);

      // PC wrap at the top of the address space
      step(); redir = 1'b1; rpc = 32'hFFFF_FFFC;
      step(); redir = 1'b0; #1;
      chk("top_req", 32'(imem_bus.req), 32'd1);
      chk("top_addr", imem_bus.addr, 32'hFFFF_FFFC);
      step();
      step(); #1;
      chk("top_valid", 32'(if_valid), 32'd1);
      chk("top_pc", pc_IF, 32'hFFFF_FFFC);
      chk("top_instr", instr_IF, 32'hA5FF_FFFC);
      step(); lat = 3; #1;
      chk("wrap_req", 32'(imem_bus.req), 32'd1);
      chk("wrap_addr", imem_bus.addr, 32'h0);

      // Reset in the middle of WAIT
      step(); rst_n = 1'b0; #1;
      chk("mrst_req", 32'(imem_bus.req), 32'd0);
      step(); rst_n = 1'b1; lat = 1; #1;
      chk("mrst_pc", pc_IF, 32'h0);
      chk("mrst_valid", 32'(if_valid), 32'd0);
      chk("mrst_instr", instr_IF, NOP_INSTR_C);
      chk("mrst_req2", 32'(imem_bus.req), 32'd1);
      chk("mrst_addr", imem_bus.addr, 32'h0);
      step();
      step(); #1;
      chk("mrst_v", 32'(if_valid), 32'd1);
      chk("mrst_vinstr", instr_IF, 32'h0050_0093);

      // Redirect in REQ: request suppressed, no drain
      step(); redir = 1'b1; rpc = 32'h40; #1;
      chk("rq_req", 32'(imem_bus.req), 32'd0);
      step(); redir = 1'b0; #1;
      chk("rq_req2", 32'(imem_bus.req), 32'd1);
      chk("rq_addr", imem_bus.addr, 32'h40);
      chk("rq_valid", 32'(if_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
